muldiv_ctrl: RTL and testbench

//  Sequencer for the RV32M multiply/divide unit. Accepts one M-extension op from the execute stage via valid/ready.

---
 rtl/muldiv_pkg.sv | 45 ++++
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_core.sv | 67 ++++++
 rtl/muldiv_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - RV32M op encodings, controller state codes and operand helpers
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_FAST = 3'd1;
   localparam logic [2:0] S_CALC = 3'd2;
   localparam logic [2:0] S_FIX  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   typedef struct packed {
      logic a_zero;
      logic a_one;
      logic a_neg1;
      logic b_zero;
      logic b_one;
      logic b_neg1;
   } opnd_flags_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_rem(input logic [2:0] op);
      return op[2] & op[1];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == OP_MUL) | (op == OP_MULH) | (op == OP_MULHSU) |
             (op == OP_DIV) | (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == OP_MUL) | (op == OP_MULH) | (op == OP_DIV) | (op == OP_REM);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - execute-stage request / writeback result bundle for the mul/div unit
interface muldiv_if #(parameter int XLEN = 32);

   logic            flush_i;
   logic            req_valid_i;
   logic            req_ready_o;
   logic [2:0]      op_i;
   logic [XLEN-1:0] rs1_i;
   logic [XLEN-1:0] rs2_i;
   logic            res_valid_o;
   logic            res_ready_i;
   logic [XLEN-1:0] res_o;
   logic            busy_o;

   modport master (
      output flush_i, req_valid_i, op_i, rs1_i, rs2_i, res_ready_i,
      input  req_ready_o, res_valid_o, res_o, busy_o
   );

   modport slave (
      input  flush_i, req_valid_i, op_i, rs1_i, rs2_i, res_ready_i,
      output req_ready_o, res_valid_o, res_o, busy_o
   );

endinterface

// File: rtl/muldiv_core.sv
// rtl/muldiv_core.sv - unsigned shift-add multiply / restoring divide datapath, STEP_BITS per step
module muldiv_core #(
   parameter int XLEN      = 32,
   parameter int STEP_BITS = 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start,
   input  logic              step,
   input  logic              last,
   input  logic              div,
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   output logic              done,
   output logic [2*XLEN-1:0] acc
);

   logic [2*XLEN-1:0] acc_q;
   logic [2*XLEN-1:0] acc_nxt;
   logic [XLEN-1:0]   opnd_q;
   logic              div_q;

   // Multiply: {partial, multiplier} shifts right; the multiplicand is added into the top half.
   function automatic logic [2*XLEN-1:0] mul_bit(input logic [2*XLEN-1:0] cur,
                                                 input logic [XLEN-1:0]   mcand);
      logic [XLEN:0] sum;
      sum = {1'b0, cur[2*XLEN-1:XLEN]} + (cur[0] ? {1'b0, mcand} : '0);
      return {sum, cur[XLEN-1:1]};
   endfunction

   // Divide: {remainder, dividend} shifts left; quotient bits fill in from the bottom.
   function automatic logic [2*XLEN-1:0] div_bit(input logic [2*XLEN-1:0] cur,
                                                 input logic [XLEN-1:0]   dvs);
      logic [XLEN:0] tmp;
      logic [XLEN:0] diff;
      tmp  = cur[2*XLEN-1:XLEN-1];
      diff = tmp - {1'b0, dvs};
      if (!diff[XLEN])
         return {diff[XLEN-1:0], cur[XLEN-2:0], 1'b1};
      else
         return {tmp[XLEN-1:0], cur[XLEN-2:0], 1'b0};
   endfunction

   always_comb begin
      acc_nxt = acc_q;
      for (int i = 0; i < STEP_BITS; i++)
         acc_nxt = div_q ? div_bit(acc_nxt, opnd_q) : mul_bit(acc_nxt, opnd_q);
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         acc_q  <= '0;
         opnd_q <= '0;
         div_q  <= 1'b0;
      end else if (start) begin
         div_q  <= div;
         acc_q  <= {{XLEN{1'b0}}, (div ? a : b)};
         opnd_q <= div ? b : a;
      end else if (step) begin
         acc_q  <= acc_nxt;
      end
   end

   assign done = step & last;
   assign acc  = acc_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - RV32M mul/div sequencer: classify, fast-resolve, iterate, sign-fix, hold result
// MULDIV_FASTPATH_EN widens the set of operand patterns resolved without iterating.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int STEP_BITS = 1
) (
   input logic     clk_i,
   input logic     reset_i,
   muldiv_if.slave bus
);

   localparam int NSTEP = XLEN / STEP_BITS;
   localparam int CNT_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

`ifdef MULDIV_FASTPATH_EN
   localparam logic FAST_EN = 1'b1;
`else
   localparam logic FAST_EN = 1'b0;
`endif

   logic [2:0]        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              core_loaded_q;
   logic [2:0]        op_q;
   logic [XLEN-1:0]   rs1_q;
   logic [XLEN-1:0]   rs2_q;
   logic [XLEN-1:0]   mag_a_q;
   logic [XLEN-1:0]   mag_b_q;
   opnd_flags_t       flg_q;
   logic              neg_q;
   logic [XLEN-1:0]   res_q;

   logic              sa;
   logic              sb;
   opnd_flags_t       flg_d;
   logic              fast_hit;
   logic [XLEN-1:0]   fast_res;
   logic [XLEN-1:0]   fix_res;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   dsel;

   logic              core_start;
   logic              core_step;
   logic              core_done;
   logic [2*XLEN-1:0] core_acc;

   assign sa = is_signed_a(bus.op_i) & bus.rs1_i[XLEN-1];
   assign sb = is_signed_b(bus.op_i) & bus.rs2_i[XLEN-1];

   always_comb begin
      flg_d.a_zero = (bus.rs1_i == '0);
      flg_d.a_one  = (bus.rs1_i == XLEN'(1));
      flg_d.a_neg1 = &bus.rs1_i;
      flg_d.b_zero = (bus.rs2_i == '0);
      flg_d.b_one  = (bus.rs2_i == XLEN'(1));
      flg_d.b_neg1 = &bus.rs2_i;
   end

   // Divide-by-zero always short-circuits; the other trivial cases only with the fast path built in.
   always_comb begin
      fast_hit = is_div(bus.op_i) & flg_d.b_zero;
      if (FAST_EN) begin
         if (is_div(bus.op_i))
            fast_hit = fast_hit | flg_d.a_zero | flg_d.b_one |
                       (is_signed_b(bus.op_i) & flg_d.b_neg1);
         else
            fast_hit = fast_hit | flg_d.a_zero | flg_d.b_zero |
                       ((bus.op_i == OP_MUL) & (flg_d.a_one | flg_d.b_one));
      end
   end

   always_comb begin
      fast_res = '0;
      if (is_div(op_q)) begin
         if (flg_q.b_zero)
            fast_res = is_rem(op_q) ? rs1_q : '1;
         else if (flg_q.a_zero || is_rem(op_q))
            fast_res = '0;
         else if (flg_q.b_one)
            fast_res = rs1_q;
         else if (flg_q.b_neg1)
            fast_res = flg_q.a_neg1 ? XLEN'(1) : -rs1_q;
      end else begin
         if (flg_q.a_zero || flg_q.b_zero)
            fast_res = '0;
         else if (flg_q.b_one)
            fast_res = rs1_q;
         else if (flg_q.a_one)
            fast_res = rs2_q;
      end
   end

   always_comb begin
      prod_s = neg_q ? -core_acc : core_acc;
      dsel   = is_rem(op_q) ? core_acc[2*XLEN-1:XLEN] : core_acc[XLEN-1:0];
      if (is_div(op_q))
         fix_res = neg_q ? -dsel : dsel;
      else if (op_q == OP_MUL)
         fix_res = prod_s[XLEN-1:0];
      else
         fix_res = prod_s[2*XLEN-1:XLEN];
   end

   // First CALC cycle loads the core from the registered magnitudes; stepping starts after.
   assign core_start = (state_q == S_CALC) & ~core_loaded_q;
   assign core_step  = (state_q == S_CALC) &  core_loaded_q;

   muldiv_core #(.XLEN(XLEN), .STEP_BITS(STEP_BITS)) u_core (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .start   (core_start),
      .step    (core_step),
      .last    (cnt_q == CNT_LAST),
      .div     (is_div(op_q)),
      .a       (mag_a_q),
      .b       (mag_b_q),
      .done    (core_done),
      .acc     (core_acc)
   );

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         core_loaded_q <= 1'b0;
         op_q          <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         mag_a_q       <= '0;
         mag_b_q       <= '0;
         flg_q         <= '0;
         neg_q         <= 1'b0;
         res_q         <= '0;
      end else if (bus.flush_i) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         core_loaded_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid_i) begin
                  op_q          <= bus.op_i;
                  rs1_q         <= bus.rs1_i;
                  rs2_q         <= bus.rs2_i;
                  mag_a_q       <= sa ? -bus.rs1_i : bus.rs1_i;
                  mag_b_q       <= sb ? -bus.rs2_i : bus.rs2_i;
                  flg_q         <= flg_d;
                  neg_q         <= is_rem(bus.op_i) ? sa : (sa ^ sb);
                  cnt_q         <= '0;
                  core_loaded_q <= 1'b0;
                  state_q       <= fast_hit ? S_FAST : S_CALC;
               end
            end
            S_FAST: begin
               res_q   <= fast_res;
               state_q <= S_DONE;
            end
            S_CALC: begin
               if (!core_loaded_q)
                  core_loaded_q <= 1'b1;
               else if (core_done)
                  state_q <= S_FIX;
               else
                  cnt_q <= cnt_q + CNT_W'(1);
            end
            S_FIX: begin
               res_q   <= fix_res;
               state_q <= S_DONE;
            end
            S_DONE: begin
               if (bus.res_ready_i)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready_o = (state_q == S_IDLE) & ~bus.flush_i;
   assign bus.res_valid_o = (state_q == S_DONE);
   assign bus.busy_o      = (state_q != S_IDLE);
   assign bus.res_o       = res_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb/tb_muldiv_ctrl.sv - scoreboard bench for muldiv_ctrl; latencies follow MULDIV_FASTPATH_EN
module tb_muldiv_ctrl;
   import muldiv_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   muldiv_if #(.XLEN(32)) bus();

   muldiv_ctrl #(.XLEN(32), .STEP_BITS(1)) dut (
      .clk_i   (clk),
      .reset_i (rst_n),
      .bus     (bus)
   );

`ifdef MULDIV_FASTPATH_EN
   localparam int LAT_OPT = 1;
`else
   localparam int LAT_OPT = 34;
`endif
   localparam int LAT_IT   = 34;
   localparam int LAT_FAST = 1;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   int   last_acc = 0;
   int   vec_id = 0;
   int   hs_cyc = 0;
   bit   prev_valid = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_total++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, want);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         prev_valid = 1'b0;
      end else begin
         if (bus.res_valid_o && !prev_valid) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_result: got %h expected no result", bus.res_o);
            end else begin
               e = sb.pop_front();
               chk($sformatf("res_v%0d", e.id), bus.res_o, e.res);
               chk($sformatf("lat_v%0d", e.id), 32'(cyc - e.acc), 32'(e.lat));
            end
         end
         prev_valid = bus.res_valid_o;
      end
   end

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] want, input int lat, input bit track);
      int w = 0;
      @(negedge clk);
      while (!bus.req_ready_o && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("req_ready_wait", {31'b0, bus.req_ready_o}, 32'd1);
      bus.op_i        = op;
      bus.rs1_i       = a;
      bus.rs2_i       = b;
      bus.req_valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid_i = 1'b0;
      last_acc = cyc;
      vec_id++;
      if (track) sb.push_back('{want, lat, cyc, vec_id});
   endtask

   task automatic wait_drain();
      int w = 0;
      while ((sb.size() != 0 || bus.busy_o) && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         n_total++;
         $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      end
   endtask

   task automatic wait_valid();
      int w = 0;
      while (!bus.res_valid_o && w < 100) begin
         @(negedge clk);
         w++;
      end
      if (w >= 100) begin
         n_total++;
         $display("FAIL valid_timeout: got res_valid 0 expected 1");
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.flush_i     = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.op_i        = '0;
      bus.rs1_i       = '0;
      bus.rs2_i       = '0;
      bus.res_ready_i = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_res_valid", {31'b0, bus.res_valid_o}, 32'd0);
      chk("rst_busy",      {31'b0, bus.busy_o},      32'd0);
      chk("rst_res",       bus.res_o,                32'd0);
      chk("rst_req_ready", {31'b0, bus.req_ready_o}, 32'd1);
      rst_n = 1'b1;

      issue(OP_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, LAT_IT,   1);
      issue(OP_MULH,   32'h7,        32'hFFFFFFFD, 32'hFFFFFFFF, LAT_IT,   1);
      issue(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, LAT_OPT,  1);
      issue(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, LAT_OPT,  1);
      issue(OP_DIVU,   32'h1234,     32'h0,        32'hFFFFFFFF, LAT_FAST, 1);
      issue(OP_REMU,   32'h1234,     32'h0,        32'h00001234, LAT_FAST, 1);
      issue(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT_IT,   1);
      issue(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT_IT,   1);
      issue(OP_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, LAT_IT,   1);
      issue(OP_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, LAT_IT,   1);
      issue(OP_DIVU,   32'd100,      32'd7,        32'd14,       LAT_IT,   1);
      issue(OP_REMU,   32'd100,      32'd7,        32'd2,        LAT_IT,   1);
      issue(OP_DIV,    32'd5,        32'h0,        32'hFFFFFFFF, LAT_FAST, 1);
      issue(OP_REM,    32'hFFFFFFFB, 32'h0,        32'hFFFFFFFB, LAT_FAST, 1);
      issue(OP_MUL,    32'h12345678, 32'h0,        32'h00000000, LAT_OPT,  1);
      issue(OP_MULHU,  32'h80000000, 32'h80000000, 32'h40000000, LAT_IT,   1);
      issue(OP_DIV,    32'd7,        32'hFFFFFFFF, 32'hFFFFFFF9, LAT_OPT,  1);
      wait_drain();

      // Flush ten cycles into CALC, with a competing request on the same cycle.
      issue(OP_MUL, 32'd3, 32'd5, 32'd0, 0, 0);
      repeat (10) @(negedge clk);
      chk("flush_pre_busy", {31'b0, bus.busy_o}, 32'd1);
      bus.flush_i     = 1'b1;
      bus.req_valid_i = 1'b1;
      #1;
      chk("flush_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
      @(posedge clk);
      #1;
      chk("flush_busy",      {31'b0, bus.busy_o},      32'd0);
      chk("flush_res_valid", {31'b0, bus.res_valid_o}, 32'd0);
      @(negedge clk);
      bus.flush_i     = 1'b0;
      bus.req_valid_i = 1'b0;
      chk("flush_no_accept", {31'b0, bus.busy_o}, 32'd0);
      issue(OP_MUL, 32'd3, 32'd5, 32'd15, LAT_IT, 1);
      wait_drain();

      // Consumer stalls five cycles in DONE.
      bus.res_ready_i = 1'b0;
      issue(OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_IT, 1);
      wait_valid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_res",       bus.res_o,                32'd14);
         chk("hold_res_valid", {31'b0, bus.res_valid_o}, 32'd1);
         chk("hold_req_ready", {31'b0, bus.req_ready_o}, 32'd0);
      end
      bus.res_ready_i = 1'b1;
      @(posedge clk);
      #1;
      hs_cyc = cyc;
      issue(OP_REMU, 32'd100, 32'd7, 32'd2, LAT_IT, 1);
      chk("accept_after_hs", 32'(last_acc - hs_cyc), 32'd1);
      wait_drain();

      // Flush beats a simultaneous handshake in DONE.
      bus.res_ready_i = 1'b0;
      issue(OP_DIVU, 32'd9, 32'd0, 32'hFFFFFFFF, LAT_FAST, 1);
      wait_valid();
      @(negedge clk);
      bus.flush_i     = 1'b1;
      bus.res_ready_i = 1'b1;
      @(posedge clk);
      #1;
      chk("done_flush_valid", {31'b0, bus.res_valid_o}, 32'd0);
      chk("done_flush_busy",  {31'b0, bus.busy_o},      32'd0);
      @(negedge clk);
      bus.flush_i = 1'b0;

      // Reset in the middle of an iterative op.
      issue(OP_MUL, 32'd7, 32'd5, 32'd0, 0, 0);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_res_valid", {31'b0, bus.res_valid_o}, 32'd0);
      chk("midrst_busy",      {31'b0, bus.busy_o},      32'd0);
      chk("midrst_res",       bus.res_o,                32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(OP_MUL, 32'd6, 32'd7, 32'd42, LAT_IT, 1);
      wait_drain();

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
